// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency unit
// results queue in a small FIFO and drain on idle port cycles or via a forced stall.
module riscv_wb_arbiter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            lu_valid,
   output logic            lu_ready,
   input  logic [4:0]      lu_rd,
   input  logic [XLEN-1:0] lu_data,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   output logic            pipe_stall,
   output logic            lu_pending
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_FORCE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [4:0]      r_rd_mem   [DEPTH];
   logic [XLEN-1:0] r_data_mem [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [WW-1:0]   r_wait;

   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_wb_req;
   logic            w_force;
   logic            w_grant_lu;
   logic            w_grant_wb;
   logic [CW-1:0]   w_count_next;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == FULL_CNT);
   assign w_force  = (r_state == ST_FORCE);
   assign w_wb_req = wb_we && (wb_rd != 5'd0);

   assign lu_ready   = !rst && !w_full;
   assign lu_pending = !rst && !w_empty;
   assign pipe_stall = !rst && w_force;

   // Writes to x0 are acknowledged on the handshake but never stored.
   assign w_push = lu_valid && lu_ready && (lu_rd != 5'd0);

   // FORCE overrides the pipeline; otherwise the head only wins an otherwise idle port.
   assign w_grant_lu = !w_empty && (w_force || !w_wb_req);
   assign w_grant_wb = !w_force && w_wb_req;
   assign w_pop      = !rst && w_grant_lu;

   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   always_comb begin
      rf_we    = 1'b0;
      rf_rd    = '0;
      rf_wdata = '0;
      if (!rst) begin
         if (w_grant_lu) begin
            rf_we    = 1'b1;
            rf_rd    = r_rd_mem[r_rptr];
            rf_wdata = r_data_mem[r_rptr];
         end else if (w_grant_wb) begin
            rf_we    = 1'b1;
            rf_rd    = wb_rd;
            rf_wdata = wb_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd_mem[r_wptr]   <= lu_rd;
         r_data_mem[r_wptr] <= lu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_empty || w_pop) begin
         r_wait <= '0;
      end else if (r_wait != WAIT_MAX) begin
         r_wait <= r_wait + WW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_push) w_state_next = ST_PEND;
         end
         ST_PEND: begin
            if (!w_empty && !w_grant_lu && (r_wait == WAIT_MAX))
               w_state_next = ST_FORCE;
            else if (w_count_next == '0)
               w_state_next = ST_IDLE;
         end
         ST_FORCE: begin
            w_state_next = (w_count_next != '0) ? ST_PEND : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed-vector bench: stimulus pushes expected regfile writes into a queue, and a
// negedge monitor pops and compares every cycle the port is (or should be) written.
module tb_riscv_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_drv = 1'b1;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        lu_valid = 1'b0;
   logic        lu_ready;
   logic [4:0]  lu_rd = '0;
   logic [31:0] lu_data = '0;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        pipe_stall;
   logic        lu_pending;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        stall;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   riscv_wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .pipe_stall(pipe_stall), .lu_pending(lu_pending)
   );

   always #5 clk = ~clk;

   // Monitor: every cycle either a queued write must appear or the port must be quiet.
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (rf_we) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%h stall=%0b, required no write",
                     rf_rd, rf_wdata, pipe_stall);
         end else begin
            e = q.pop_front();
            if (rf_rd !== e.rd || rf_wdata !== e.data || pipe_stall !== e.stall) begin
               errors++;
               $display("FAIL write_data: got rd=%0d data=%h stall=%0b, required rd=%0d data=%h stall=%0b",
                        rf_rd, rf_wdata, pipe_stall, e.rd, e.data, e.stall);
            end
         end
      end else begin
         if (q.size() != 0 || pipe_stall !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL idle_port: got we=0 rd=%0d data=%h stall=%0b, required %0d write(s) queued=0 and zero outputs",
                     rf_rd, rf_wdata, pipe_stall, q.size());
            if (q.size() != 0) void'(q.pop_front());
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // One clock cycle: drive inputs after the edge, register the expected write, stop at negedge.
   task automatic cyc(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                      input logic es);
      exp_t e;
      @(posedge clk);
      #1;
      rst      = rst_drv;
      wb_we    = we;
      wb_rd    = wrd;
      wb_data  = wd;
      lu_valid = lv;
      lu_rd    = lrd;
      lu_data  = ld;
      if (ew) begin
         e.rd = erd; e.data = ed; e.stall = es;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset
      rst_drv = 1'b1;
      idle();
      chk("rst_lu_ready", lu_ready, 0);
      chk("rst_lu_pending", lu_pending, 0);
      idle();
      rst_drv = 1'b0;

      // Idle drain
      cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      chk("drain_ready", lu_ready, 1);
      chk("drain_pending_before", lu_pending, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
      chk("drain_pending_head", lu_pending, 1);
      idle();
      chk("drain_pending_after", lu_pending, 0);

      // Priority with starvation: 4 pipeline wins, then a forced LU write
      cyc(1, 3, 32'h11, 1, 9, 32'hA5A50009, 1, 3, 32'h11, 0);
      repeat (4) cyc(1, 3, 32'h11, 0, 0, 0, 1, 3, 32'h11, 0);
      cyc(1, 3, 32'h11, 0, 0, 0, 1, 9, 32'hA5A50009, 1);
      cyc(1, 3, 32'h11, 0, 0, 0, 1, 3, 32'h11, 0);
      idle();

      // x0 handling
      cyc(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
      cyc(1, 0, 32'hFF, 0, 0, 0, 1, 7, 32'h77, 0);
      cyc(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0);
      chk("x0_ready", lu_ready, 1);
      idle();
      chk("x0_pending", lu_pending, 0);

      // Full FIFO with a third request held until the forced pop
      cyc(1, 3, 32'h22, 1, 10, 32'hA, 1, 3, 32'h22, 0);
      cyc(1, 3, 32'h22, 1, 11, 32'hB, 1, 3, 32'h22, 0);
      chk("full_ready_c2", lu_ready, 1);
      repeat (3) begin
         cyc(1, 3, 32'h22, 1, 12, 32'hC, 1, 3, 32'h22, 0);
         chk("full_ready_low", lu_ready, 0);
      end
      cyc(1, 3, 32'h22, 1, 12, 32'hC, 1, 10, 32'hA, 1);
      chk("full_ready_force", lu_ready, 0);
      cyc(1, 3, 32'h22, 1, 12, 32'hC, 1, 3, 32'h22, 0);
      chk("full_ready_after", lu_ready, 1);
      repeat (3) cyc(1, 3, 32'h22, 0, 0, 0, 1, 3, 32'h22, 0);
      cyc(1, 3, 32'h22, 0, 0, 0, 1, 11, 32'hB, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 12, 32'hC, 0);
      idle();
      chk("full_pending_end", lu_pending, 0);

      // Push during FORCE with one entry: wait count restarts from zero
      cyc(1, 3, 32'h33, 1, 13, 32'hD, 1, 3, 32'h33, 0);
      repeat (4) cyc(1, 3, 32'h33, 0, 0, 0, 1, 3, 32'h33, 0);
      cyc(1, 3, 32'h33, 1, 14, 32'hE, 1, 13, 32'hD, 1);
      chk("force_push_ready", lu_ready, 1);
      repeat (4) cyc(1, 3, 32'h33, 0, 0, 0, 1, 3, 32'h33, 0);
      cyc(1, 3, 32'h33, 0, 0, 0, 1, 14, 32'hE, 1);
      idle();
      chk("force_push_pending_end", lu_pending, 0);

      // Reset with two queued entries flushes them
      cyc(1, 3, 32'h44, 1, 15, 32'hF1, 1, 3, 32'h44, 0);
      cyc(1, 3, 32'h44, 1, 16, 32'hF2, 1, 3, 32'h44, 0);
      chk("midrst_pending_before", lu_pending, 1);
      rst_drv = 1'b1;
      cyc(1, 3, 32'h44, 0, 0, 0, 0, 0, 0, 0);
      chk("midrst_ready", lu_ready, 0);
      chk("midrst_pending", lu_pending, 0);
      rst_drv = 1'b0;
      idle();
      chk("postrst_pending", lu_pending, 0);
      chk("postrst_ready", lu_ready, 1);
      idle();

      #2;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
